// File: rtl/obi_mem_arb_pkg.sv
// Shared types for the instr/data OBI arbiter in front of the single-port word memory.
package obi_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef enum logic {
    FAV_DATA  = 1'b0,
    FAV_INSTR = 1'b1
  } arb_state_e;

  typedef struct packed {
    owner_e owner;
    logic   we;
  } rsp_entry_t;

  localparam rsp_entry_t RSP_IDLE = '{owner: OWN_NONE, we: 1'b0};
  localparam logic [3:0] BE_ALL   = 4'hF;

endpackage

// File: rtl/obi_mem_arb_rsp_pipe.sv
// Tracks who owns each outstanding memory access; the head entry lines up with
// the read data coming back MEM_LAT cycles after the grant.
module obi_mem_arb_rsp_pipe
  import obi_mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  rsp_entry_t i_entry,
  output rsp_entry_t o_head
);

  rsp_entry_t r_pipe [MEM_LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < MEM_LAT; k++) r_pipe[k] <= RSP_IDLE;
    end else begin
      r_pipe[0] <= i_entry;
      for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_head = r_pipe[MEM_LAT-1];

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-port synchronous word memory between the cv32e40p instr and
// data OBI ports: one combinational grant per cycle, in-order response routing.
module obi_mem_arbiter
  import obi_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_cnt_nxt;
  logic             w_instr_gnt, w_data_gnt;
  rsp_entry_t       w_rsp_in, w_rsp_head;
  logic             w_unused_addr_lsbs;

  // Byte offsets never reach the word memory.
  assign w_unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= FAV_DATA;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_starve_cnt;
    // Grants are suppressed while reset is held so the memory sees no access.
    if (!rst_i) begin
      unique case (r_state)
        FAV_INSTR: begin
          w_instr_gnt = instr_req_i;
          w_data_gnt  = data_req_i & ~instr_req_i;
        end
        default: begin
          w_data_gnt  = data_req_i;
          w_instr_gnt = instr_req_i & ~data_req_i;
        end
      endcase
    end
    if (w_instr_gnt || !instr_req_i) w_cnt_nxt = '0;
    else if (r_starve_cnt != LIMIT_C) w_cnt_nxt = r_starve_cnt + CNT_W'(1);
    unique case (r_state)
      FAV_INSTR: if (w_instr_gnt) w_state_nxt = FAV_DATA;
      default:   if (w_cnt_nxt == LIMIT_C) w_state_nxt = FAV_INSTR;
    endcase
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    w_rsp_in    = RSP_IDLE;
    if (w_instr_gnt) begin
      mem_addr_o     = {instr_addr_i[ADDR_W-1:2], 2'b00};
      mem_be_o       = BE_ALL;
      w_rsp_in.owner = OWN_INSTR;
    end else if (w_data_gnt) begin
      mem_addr_o     = {data_addr_i[ADDR_W-1:2], 2'b00};
      mem_we_o       = data_we_i;
      mem_be_o       = data_be_i;
      mem_wdata_o    = data_wdata_i;
      w_rsp_in.owner = OWN_DATA;
      w_rsp_in.we    = data_we_i;
    end
  end

  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;
  assign mem_req_o   = w_instr_gnt | w_data_gnt;

  obi_mem_arb_rsp_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rsp_pipe (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_entry (w_rsp_in),
    .o_head  (w_rsp_head)
  );

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = 32'h0;
    // Write acks carry no data; the memory bus is undefined on those cycles.
    unique case (w_rsp_head.owner)
      OWN_INSTR: begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
      end
      OWN_DATA: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = w_rsp_head.we ? 32'h0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule
